// File: rtl/if_id_hazard_ctrl_pkg.sv
// Shared definitions for the IF/ID hazard controller: state encoding, NOP word
// and the load-use hazard detector.
package if_id_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_IMEM_WAIT = 2'd1,
        ST_DRAIN     = 2'd2,
        ST_HALTED    = 2'd3
    } state_e;

    // addi x0, x0, 0 -- what the IF/ID wrapper loads on IF_ID_flush
    localparam logic [31:0] NOP_INSN = 32'h00000013;

    function automatic logic load_use_hit(
        input logic       mem_read_ex,
        input logic [4:0] rd_ex,
        input logic       use_rs1,
        input logic [4:0] rs1,
        input logic       use_rs2,
        input logic [4:0] rs2
    );
        return mem_read_ex && (rd_ex != 5'd0) &&
               ((use_rs1 && (rs1 == rd_ex)) || (use_rs2 && (rs2 == rd_ex)));
    endfunction

endpackage

// File: rtl/if_id_hazard_ctrl_sat_counter.sv
// Saturating up-counter with async active-low reset and a synchronous clear.
// Clear together with inc loads 1, which lets a counter restart at one.
module if_id_hazard_ctrl_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= W'(i_inc);
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/if_id_hazard_ctrl.sv
// IF/ID front-end control: load-use stalls, branch flushes, IMEM wait states
// and halt/drain/resume, with saturating stall/flush counters and a timeout flag.
module if_id_hazard_ctrl
    import if_id_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int DRAIN_CYCLES = 3,
    parameter int WAIT_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       RS1_ID,
    input  logic [4:0]       RS2_ID,
    input  logic             USE_RS1_ID,
    input  logic             USE_RS2_ID,
    input  logic             MemRead_EX,
    input  logic [4:0]       RD_EX,
    input  logic             PCSrc,
    input  logic             imem_ready,
    input  logic             halt_req,
    input  logic             resume,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             halted,
    output logic             timeout_err,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = $clog2(WAIT_TIMEOUT + 1);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(WAIT_TIMEOUT);
    localparam logic [DRAIN_W-1:0] DRAIN_LIMIT = DRAIN_W'(DRAIN_CYCLES);

    state_e              r_state;
    state_e              w_next;
    logic                r_resume_mask;
    logic                r_timeout_err;
    logic                w_load_use;
    logic                w_halt_ok;
    logic                w_timeout_hit;
    logic                w_pc_write;
    logic                w_if_id_write;
    logic                w_if_id_flush;
    logic                w_id_ex_flush;
    logic                w_stall_inc;
    logic                w_flush_inc;
    logic                w_wait_clr;
    logic                w_wait_inc;
    logic                w_drain_clr;
    logic                w_drain_inc;
    logic [WAIT_W-1:0]   w_wait_cnt;
    logic [DRAIN_W-1:0]  w_drain_cnt;

    assign w_load_use = load_use_hit(MemRead_EX, RD_EX, USE_RS1_ID, RS1_ID,
                                     USE_RS2_ID, RS2_ID);
    // The first RUN cycle after resume ignores a still-high halt_req.
    assign w_halt_ok  = halt_req && !r_resume_mask;

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next        = r_state;
        w_pc_write    = 1'b1;
        w_if_id_write = 1'b1;
        w_if_id_flush = 1'b0;
        w_id_ex_flush = 1'b0;
        w_stall_inc   = 1'b0;
        w_flush_inc   = 1'b0;
        w_wait_clr    = 1'b1;
        w_wait_inc    = 1'b0;
        w_drain_clr   = 1'b1;
        w_drain_inc   = 1'b0;

        case (r_state)
            ST_RUN, ST_IMEM_WAIT: begin
                if (PCSrc) begin
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = 1'b1;
                    w_flush_inc   = 1'b1;
                    w_next        = (r_state == ST_IMEM_WAIT && !imem_ready) ?
                                    ST_IMEM_WAIT : ST_RUN;
                end else if (r_state == ST_IMEM_WAIT && !imem_ready) begin
                    w_pc_write    = 1'b0;
                    w_if_id_flush = 1'b1;
                    w_stall_inc   = 1'b1;
                    w_wait_clr    = 1'b0;
                    w_wait_inc    = (w_wait_cnt < WAIT_LIMIT);
                end else if (w_load_use) begin
                    w_pc_write    = 1'b0;
                    w_if_id_write = 1'b0;
                    w_id_ex_flush = 1'b1;
                    w_stall_inc   = 1'b1;
                    w_next        = ST_RUN;
                end else if (!imem_ready) begin
                    w_pc_write    = 1'b0;
                    w_if_id_flush = 1'b1;
                    w_stall_inc   = 1'b1;
                    w_wait_inc    = 1'b1;
                    w_next        = ST_IMEM_WAIT;
                end else if (w_halt_ok) begin
                    w_pc_write    = 1'b0;
                    w_if_id_flush = 1'b1;
                    w_drain_inc   = 1'b1;
                    w_next        = ST_DRAIN;
                end else begin
                    w_next        = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // A branch redirect still writes PC so fetch restarts there on resume.
                w_pc_write    = PCSrc;
                w_if_id_flush = 1'b1;
                w_id_ex_flush = PCSrc || w_load_use;
                w_flush_inc   = PCSrc;
                w_drain_clr   = 1'b0;
                w_drain_inc   = 1'b1;
                if (w_drain_cnt >= DRAIN_LIMIT) begin
                    w_next = ST_HALTED;
                end
            end
            ST_HALTED: begin
                w_pc_write    = 1'b0;
                w_if_id_write = 1'b0;
                w_if_id_flush = 1'b1;
                w_id_ex_flush = 1'b1;
                if (resume) begin
                    w_next = ST_RUN;
                end
            end
        endcase
    end

    assign w_timeout_hit = (r_state == ST_IMEM_WAIT) && (w_wait_cnt == WAIT_LIMIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_RUN;
            r_resume_mask <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_resume_mask <= (r_state == ST_HALTED) && resume;
            r_timeout_err <= r_timeout_err || w_timeout_hit;
        end
    end

    if_id_hazard_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk(clk), .rst_n(reset), .i_clr(1'b0), .i_inc(w_stall_inc), .o_cnt(stall_cnt)
    );

    if_id_hazard_ctrl_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk(clk), .rst_n(reset), .i_clr(1'b0), .i_inc(w_flush_inc), .o_cnt(flush_cnt)
    );

    if_id_hazard_ctrl_sat_counter #(.W(WAIT_W)) u_wait_cnt (
        .clk(clk), .rst_n(reset), .i_clr(w_wait_clr), .i_inc(w_wait_inc), .o_cnt(w_wait_cnt)
    );

    if_id_hazard_ctrl_sat_counter #(.W(DRAIN_W)) u_drain_cnt (
        .clk(clk), .rst_n(reset), .i_clr(w_drain_clr), .i_inc(w_drain_inc), .o_cnt(w_drain_cnt)
    );

    // Reset overrides the control outputs combinationally, with no edge needed.
    assign PC_write    = reset && w_pc_write;
    assign IF_ID_write = reset && w_if_id_write;
    assign IF_ID_flush = !reset || w_if_id_flush;
    assign ID_EX_flush = !reset || w_id_ex_flush;
    assign halted      = reset && (r_state == ST_HALTED);
    assign timeout_err = r_timeout_err || w_timeout_hit;
    assign state_o     = r_state;

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// Directed scoreboard bench for if_id_hazard_ctrl; a second instance with a
// 4-bit counter width exercises counter saturation on the same stimulus.
module tb_if_id_hazard_ctrl;

    localparam logic [4:0] C_RUN  = 5'b11000; // {PC_w, IFID_w, IFID_fl, IDEX_fl, halted}
    localparam logic [4:0] C_LU   = 5'b00010;
    localparam logic [4:0] C_BR   = 5'b11110;
    localparam logic [4:0] C_WAIT = 5'b01100;
    localparam logic [4:0] C_DLU  = 5'b01110;
    localparam logic [4:0] C_HALT = 5'b00111;
    localparam logic [4:0] C_RST  = 5'b00110;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] rs1, rs2, rd;
    logic use1, use2, memrd, pcsrc, ready, halt, resume;

    logic pc_write, if_id_write, if_id_flush, id_ex_flush, halted, timeout_err;
    logic [1:0] state_o;
    logic [15:0] stall_cnt, flush_cnt;

    logic s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_flush, s_halted, s_timeout_err;
    logic [1:0] s_state_o;
    logic [3:0] s_stall_cnt, s_flush_cnt;

    always #5 clk = ~clk;

    if_id_hazard_ctrl u_dut (
        .clk(clk), .reset(reset), .RS1_ID(rs1), .RS2_ID(rs2),
        .USE_RS1_ID(use1), .USE_RS2_ID(use2), .MemRead_EX(memrd), .RD_EX(rd),
        .PCSrc(pcsrc), .imem_ready(ready), .halt_req(halt), .resume(resume),
        .PC_write(pc_write), .IF_ID_write(if_id_write), .IF_ID_flush(if_id_flush),
        .ID_EX_flush(id_ex_flush), .halted(halted), .timeout_err(timeout_err),
        .state_o(state_o), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    if_id_hazard_ctrl #(.CNT_W(4)) u_sat (
        .clk(clk), .reset(reset), .RS1_ID(rs1), .RS2_ID(rs2),
        .USE_RS1_ID(use1), .USE_RS2_ID(use2), .MemRead_EX(memrd), .RD_EX(rd),
        .PCSrc(pcsrc), .imem_ready(ready), .halt_req(halt), .resume(resume),
        .PC_write(s_pc_write), .IF_ID_write(s_if_id_write), .IF_ID_flush(s_if_id_flush),
        .ID_EX_flush(s_id_ex_flush), .halted(s_halted), .timeout_err(s_timeout_err),
        .state_o(s_state_o), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    typedef struct {
        string      tag;
        logic [4:0] ctl;
        logic [1:0] st;
        logic       to;
        int         stall;
        int         flush;
    } exp_t;

    exp_t exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int m_stall = 0;
    int m_flush = 0;
    logic m_to = 1'b0;

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
        use1 = 1'b0; use2 = 1'b0; memrd = 1'b0;
        pcsrc = 1'b0; ready = 1'b1; halt = 1'b0; resume = 1'b0;
    endtask

    task automatic set_lu();
        memrd = 1'b1; rd = 5'd5; rs1 = 5'd5; use1 = 1'b1;
    endtask

    // Inputs for this cycle are already driven; push the expectation, compare
    // mid-cycle, then advance the counter model by the expected increments.
    task automatic cyc(input string tag, input logic [4:0] ctl, input logic [1:0] st,
                       input int ds, input int df);
        exp_t e;
        exp_t got;
        e.tag = tag; e.ctl = ctl; e.st = st; e.to = m_to;
        e.stall = m_stall; e.flush = m_flush;
        exp_q.push_back(e);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            got = exp_q.pop_front();
            check({got.tag, ".ctl"},
                  16'({pc_write, if_id_write, if_id_flush, id_ex_flush, halted}), 16'(got.ctl));
            check({got.tag, ".state"}, 16'(state_o), 16'(got.st));
            check({got.tag, ".timeout"}, 16'(timeout_err), 16'(got.to));
            check({got.tag, ".stall"}, stall_cnt, 16'(got.stall));
            check({got.tag, ".flush"}, flush_cnt, 16'(got.flush));
            check({got.tag, ".s_ctl"},
                  16'({s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_flush, s_halted}),
                  16'(got.ctl));
            check({got.tag, ".s_state"}, 16'({s_state_o, s_timeout_err}), 16'({got.st, got.to}));
            check({got.tag, ".s_stall"}, 16'(s_stall_cnt), 16'(sat(got.stall, 15)));
            check({got.tag, ".s_flush"}, 16'(s_flush_cnt), 16'(sat(got.flush, 15)));
        end
        @(posedge clk);
        #1;
        m_stall = sat(m_stall + ds, 65535);
        m_flush = sat(m_flush + df, 65535);
        set_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        set_idle();
        reset = 1'b0;
        @(posedge clk);
        #1;
        cyc("reset", C_RST, 2'd0, 0, 0);
        reset = 1'b1;
        cyc("idle", C_RUN, 2'd0, 0, 0);

        set_lu();                                        cyc("lu_rs1", C_LU, 2'd0, 1, 0);
        cyc("lu_gone", C_RUN, 2'd0, 0, 0);
        memrd = 1; rd = 5'd0; rs1 = 5'd0; use1 = 1;      cyc("lu_x0", C_RUN, 2'd0, 0, 0);
        memrd = 1; rd = 5'd7; rs1 = 5'd3; rs2 = 5'd7; use2 = 1;
        cyc("lu_rs2", C_LU, 2'd0, 1, 0);
        memrd = 1; rd = 5'd7; rs1 = 5'd7; use1 = 0;      cyc("lu_nouse", C_RUN, 2'd0, 0, 0);
        memrd = 0; rd = 5'd5; rs1 = 5'd5; use1 = 1;      cyc("no_load", C_RUN, 2'd0, 0, 0);
        set_lu(); pcsrc = 1;                             cyc("br_over_lu", C_BR, 2'd0, 0, 1);
        cyc("after_br", C_RUN, 2'd0, 0, 0);

        ready = 0;                                       cyc("wait_enter", C_WAIT, 2'd0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            ready = 0;                                   cyc("wait", C_WAIT, 2'd1, 1, 0);
        end
        cyc("wait_done", C_RUN, 2'd1, 0, 0);
        cyc("wait_run", C_RUN, 2'd0, 0, 0);

        ready = 0;                                       cyc("wait2_enter", C_WAIT, 2'd0, 1, 0);
        ready = 0; set_lu();                             cyc("wait_lu_ign", C_WAIT, 2'd1, 1, 0);
        ready = 0; pcsrc = 1;                            cyc("wait_br", C_BR, 2'd1, 0, 1);
        ready = 0;                                       cyc("wait_after_br", C_WAIT, 2'd1, 1, 0);
        set_lu();                                        cyc("wait_ready_lu", C_LU, 2'd1, 1, 0);
        cyc("run_again", C_RUN, 2'd0, 0, 0);

        halt = 1;                                        cyc("halt_acc", C_WAIT, 2'd0, 0, 0);
        cyc("drain1", C_WAIT, 2'd2, 0, 0);
        pcsrc = 1;                                       cyc("drain_br", C_BR, 2'd2, 0, 1);
        cyc("drain3", C_WAIT, 2'd2, 0, 0);
        pcsrc = 1;                                       cyc("halted_br_ign", C_HALT, 2'd3, 0, 0);
        halt = 1; resume = 1;                            cyc("halted_resume", C_HALT, 2'd3, 0, 0);
        halt = 1;                                        cyc("resume_run", C_RUN, 2'd0, 0, 0);
        halt = 1;                                        cyc("halt_reeval", C_WAIT, 2'd0, 0, 0);
        set_lu();                                        cyc("drain_lu", C_DLU, 2'd2, 0, 0);
        cyc("drain2b", C_WAIT, 2'd2, 0, 0);
        cyc("drain3b", C_WAIT, 2'd2, 0, 0);
        cyc("halted2", C_HALT, 2'd3, 0, 0);
        resume = 1;                                      cyc("resume2", C_HALT, 2'd3, 0, 0);
        cyc("run_pc", C_RUN, 2'd0, 0, 0);

        ready = 0;                                       cyc("to_enter", C_WAIT, 2'd0, 1, 0);
        for (int i = 2; i <= 64; i++) begin
            ready = 0;                                   cyc("to_wait", C_WAIT, 2'd1, 1, 0);
        end
        m_to = 1'b1;
        ready = 0;                                       cyc("to_hit", C_WAIT, 2'd1, 1, 0);
        ready = 0;                                       cyc("to_hold", C_WAIT, 2'd1, 1, 0);
        cyc("to_ready", C_RUN, 2'd1, 0, 0);
        cyc("to_sticky", C_RUN, 2'd0, 0, 0);

        ready = 0;                                       cyc("rst_pre", C_WAIT, 2'd0, 1, 0);
        ready = 0;                                       cyc("rst_pre2", C_WAIT, 2'd1, 1, 0);
        ready = 0; reset = 0;
        m_stall = 0; m_flush = 0; m_to = 1'b0;
        cyc("rst_mid", C_RST, 2'd0, 0, 0);
        reset = 1;
        cyc("rst_release", C_RUN, 2'd0, 0, 0);

        for (int i = 0; i < 20; i++) begin
            set_lu();                                    cyc("lu_sat", C_LU, 2'd0, 1, 0);
        end
        cyc("sat_hold", C_RUN, 2'd0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_id_hazard_ctrl.md
Name: if_id_hazard_ctrl

Overview:
- Pipeline control unit for the IF/ID front end. Generates PC_write, IF_ID_write and the bubble/flush controls.
- Handles four events: load-use stalls, taken-branch flushes, instruction-memory wait states, and halt/drain/resume.
- Sits beside the IF and ID stages and drives the control inputs of the IF/ID pipeline wrapper. Also exposes saturating stall/flush counters and a timeout error flag.

Parameters:
CNT_W, 16, width of stall_cnt and flush_cnt (saturating)
DRAIN_CYCLES, 3, cycles fetch is suppressed after halt acceptance before HALTED
WAIT_TIMEOUT, 64, consecutive IMEM_WAIT cycles before timeout_err sets

Ports:
clk  in  1  global clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
RS1_ID  in  5  rs1 of instruction in ID
RS2_ID  in  5  rs2 of instruction in ID
USE_RS1_ID  in  1  ID instruction reads rs1
USE_RS2_ID  in  1  ID instruction reads rs2
MemRead_EX  in  1  instruction in EX is a load
RD_EX  in  5  destination of instruction in EX
PCSrc  in  1  branch resolved taken in EX (PC_Branch valid)
imem_ready  in  1  instruction memory returns valid data this cycle
halt_req  in  1  request pipeline halt (level)
resume  in  1  leave HALTED (pulse)
PC_write  out  1  PC register enable
IF_ID_write  out  1  IF/ID register enable
IF_ID_flush  out  1  load NOP into IF/ID
ID_EX_flush  out  1  zero ID control signals (bubble into EX)
halted  out  1  state == HALTED
timeout_err  out  1  sticky; IMEM_WAIT exceeded WAIT_TIMEOUT
state_o  out  2  RUN=0, IMEM_WAIT=1, DRAIN=2, HALTED=3
stall_cnt  out  CNT_W  load-use + imem-wait stall cycles
flush_cnt  out  CNT_W  taken-branch flush events

Behaviour:
- Reset (reset=0, async):
  - State goes to RUN. Counters, drain/timeout counters and timeout_err clear.
  - While reset is low, outputs are forced: PC_write=0, IF_ID_write=0, IF_ID_flush=1, ID_EX_flush=1, halted=0.
- Output timing: outputs are combinational from registered state plus current inputs, so event response has 0-cycle latency. State and counters update on the clk rising edge.
- load_use = MemRead_EX & RD_EX!=0 & ((USE_RS1_ID & RS1_ID==RD_EX) | (USE_RS2_ID & RS2_ID==RD_EX)).
- Default outputs in RUN, no event: PC_write=1, IF_ID_write=1, flushes=0.
- RUN, event priority PCSrc > load_use > !imem_ready > halt_req:
  - PCSrc: PC_write=1, IF_ID_write=1, IF_ID_flush=1, ID_EX_flush=1. flush_cnt+1. Stay in RUN. A concurrent load_use is ignored.
  - load_use: PC_write=0, IF_ID_write=0, ID_EX_flush=1. stall_cnt+1. Stay in RUN; the hazard clears naturally next cycle, giving exactly one bubble.
  - !imem_ready: PC_write=0, IF_ID_write=1, IF_ID_flush=1. stall_cnt+1. Go to IMEM_WAIT with the wait counter set to 1.
  - halt_req: PC_write=0, IF_ID_flush=1. Go to DRAIN with the drain counter set to 1.
- IMEM_WAIT:
  - Outputs match the RUN !imem_ready case. stall_cnt+1 per cycle. The wait counter increments and saturates at WAIT_TIMEOUT, at which point timeout_err sets.
  - imem_ready=1: behave as RUN for that cycle (including load_use and halt evaluation), then next state RUN.
  - PCSrc in IMEM_WAIT: apply the PCSrc outputs, flush_cnt+1, reset the wait counter, stay in IMEM_WAIT if !imem_ready.
- DRAIN:
  - PC_write=0, IF_ID_write=1, IF_ID_flush=1, ID_EX_flush=load_use. The drain counter increments; when it reaches DRAIN_CYCLES, go to HALTED.
  - PCSrc in DRAIN: PC_write=1 (redirect is kept for resume), both flushes=1, flush_cnt+1. The drain counter continues.
  - halt_req deassertion during DRAIN is ignored.
- HALTED:
  - PC_write=0, IF_ID_write=0, IF_ID_flush=1, ID_EX_flush=1, halted=1. PCSrc is ignored.
  - resume=1 -> RUN next cycle, even if halt_req is still high. halt_req is re-evaluated after one RUN cycle.
- Counters saturate at all ones and never wrap.
- timeout_err clears only on reset.
- Mid-operation reset is asynchronous: outputs are forced immediately, with no pending event carried over.

Decomposition:
- Shared package holds the state encoding constants (RUN/IMEM_WAIT/DRAIN/HALTED) and the NOP instruction constant 32'h00000013.
- One natural sub-module: sat_counter (parameterised width, inc, async active-low clear), instantiated for stall_cnt, flush_cnt and the wait/drain counters.

Test Plan:
- Load-use: MemRead_EX=1, RD_EX=5, RS1_ID=5, USE_RS1_ID=1 for 1 cycle -> PC_write=0, IF_ID_write=0, ID_EX_flush=1 for that cycle only; stall_cnt=1. Repeat with RD_EX=0 -> no stall.
- Branch: PCSrc=1 while load_use=1 -> PC_write=1, IF_ID_flush=1, ID_EX_flush=1; flush_cnt=1, stall_cnt unchanged.
- IMEM wait: imem_ready=0 for 5 cycles, then 1 -> state_o=1 during the wait, PC_write=0, IF_ID_flush=1; stall_cnt=5; RUN after. Hold imem_ready low for 64 cycles -> timeout_err=1 and stays 1.
- Halt: halt_req=1 -> DRAIN for 3 cycles, then halted=1 with all enables 0. PCSrc during DRAIN -> PC_write=1 for that cycle. resume pulse -> RUN with PC_write=1.
- Reset: drive reset=0 mid-IMEM_WAIT with counters nonzero -> outputs forced immediately (flushes=1, enables=0), counters 0, state_o=0. After release, RUN defaults.
- Saturation: CNT_W=4, 20 load-use stalls -> stall_cnt holds at 15.
